// File: rtl/up_csr_slave_if.sv
// up_* microprocessor bus bundle between the CPU bus master and a CSR slave.
// Carries strobes, address, write data, read data and the wait request.
interface up_csr_slave_if;
    logic        up_wr;
    logic        up_rd;
    logic [31:0] up_addr;
    logic [31:0] up_data_wr;
    logic [31:0] up_data_rd;
    logic        up_wait;

    modport master (
        output up_wr, up_rd, up_addr, up_data_wr,
        input  up_data_rd, up_wait
    );

    modport slave (
        input  up_wr, up_rd, up_addr, up_data_wr,
        output up_data_rd, up_wait
    );
endinterface

// File: rtl/up_csr_slave.sv
// CSR slave on the up_* bus: ID, CTRL, SCRATCH, STATUS, snapshot counters
// and sticky IRQ flags. Ports: up_clk/up_rst, up (slave bus), ctrl,
// status_in, cnt_inc, irq_evt, irq. Read data registered, wait in N and N+1.
module up_csr_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5445_0001,
    parameter int          NUM_CNT   = 4,
    parameter logic [15:0] CTRL_RST  = 16'h0000
) (
    input  logic               up_clk,
    input  logic               up_rst,
    up_csr_slave_if.slave      up,
    output logic [15:0]        ctrl,
    input  logic [31:0]        status_in,
    input  logic [NUM_CNT-1:0] cnt_inc,
    input  logic [7:0]         irq_evt,
    output logic               irq
);

    logic        hit;
    logic [5:0]  word;
    logic        wr_en;
    logic        snap;
    logic        snap_clr;
    logic [31:0] scratch_q;
    logic [31:0] status_q;
    logic [7:0]  stat_q;
    logic [7:0]  mask_q;
    logic [7:0]  w1c;
    logic        rd_d;
    logic [31:0] rd_mux;
    logic [NUM_CNT*32-1:0] shadow_flat;
    logic        unused_ok;

    assign hit       = up.up_addr[31:8] == ADDR_BASE[31:8];
    assign word      = up.up_addr[7:2];
    assign wr_en     = up.up_wr & hit;
    assign unused_ok = ^up.up_addr[1:0];

    // Clear only qualifies a snapshot; bit1 on its own does nothing.
    assign snap      = wr_en && word == 6'h04 && up.up_data_wr[0];
    assign snap_clr  = snap && up.up_data_wr[1];
    assign w1c       = (wr_en && word == 6'h05) ? up.up_data_wr[7:0] : 8'h00;

    // Wait covers the strobe cycle (combinational) and the cycle after.
    assign up.up_wait = rd_d | (up.up_rd & ~up_rst);

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic [31:0] live_q;
        logic [31:0] shadow_q;

        always_ff @(posedge up_clk) begin
            if (up_rst) begin
                live_q   <= '0;
                shadow_q <= '0;
            end else begin
                if (snap)
                    shadow_q <= live_q;
                if (snap_clr)
                    live_q <= {31'd0, cnt_inc[i]};
                else if (cnt_inc[i] && live_q != 32'hFFFF_FFFF)
                    live_q <= live_q + 32'd1;
            end
        end

        assign shadow_flat[i*32 +: 32] = shadow_q;
    end

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (word)
                6'h00:   rd_mux = ID_VALUE;
                6'h01:   rd_mux = {16'h0000, ctrl};
                6'h02:   rd_mux = scratch_q;
                6'h03:   rd_mux = status_q;
                6'h05:   rd_mux = {24'h0, stat_q};
                6'h06:   rd_mux = {24'h0, mask_q};
                default: begin
                    for (int i = 0; i < NUM_CNT; i++)
                        if (word == 6'(8 + i))
                            rd_mux = shadow_flat[i*32 +: 32];
                end
            endcase
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            ctrl          <= CTRL_RST;
            scratch_q     <= '0;
            status_q      <= '0;
            stat_q        <= '0;
            mask_q        <= '0;
            irq           <= 1'b0;
            rd_d          <= 1'b0;
            up.up_data_rd <= '0;
        end else begin
            status_q <= status_in;
            irq      <= |(stat_q & mask_q);
            rd_d     <= up.up_rd;
            if (up.up_rd)
                up.up_data_rd <= rd_mux;
            if (wr_en && word == 6'h01)
                ctrl <= up.up_data_wr[15:0];
            if (wr_en && word == 6'h02)
                scratch_q <= up.up_data_wr;
            if (wr_en && word == 6'h06)
                mask_q <= up.up_data_wr[7:0];
            // New events win over a simultaneous W1C.
            stat_q <= (stat_q & ~w1c) | irq_evt;
        end
    end

endmodule

// File: tb/tb_up_csr_slave.sv
// Self-checking bench for up_csr_slave: directed register-map scenarios
// followed by randomized bus/event traffic compared to a behavioural model.
module tb_up_csr_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] ID   = 32'h5445_0001;
    localparam int          NC   = 4;
    localparam logic [15:0] CRST = 16'h0000;

    logic          up_clk = 1'b0;
    logic          up_rst;
    logic [15:0]   ctrl;
    logic [31:0]   status_in;
    logic [NC-1:0] cnt_inc;
    logic [7:0]    irq_evt;
    logic          irq;

    up_csr_slave_if bus ();

    up_csr_slave #(
        .ADDR_BASE (BASE),
        .ID_VALUE  (ID),
        .NUM_CNT   (NC),
        .CTRL_RST  (CRST)
    ) dut (
        .up_clk    (up_clk),
        .up_rst    (up_rst),
        .up        (bus.slave),
        .ctrl      (ctrl),
        .status_in (status_in),
        .cnt_inc   (cnt_inc),
        .irq_evt   (irq_evt),
        .irq       (irq)
    );

    always #5 up_clk = ~up_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model state.
    logic [15:0] m_ctrl;
    logic [31:0] m_scr;
    logic [31:0] m_status;
    logic [7:0]  m_stat;
    logic [7:0]  m_mask;
    logic        m_irq;
    logic [31:0] m_live   [NC];
    logic [31:0] m_shadow [NC];
    logic [31:0] m_rd;
    logic        m_pend;
    logic        chk_en = 1'b0;

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [7:0] off;
        if (a[31:8] != BASE[31:8]) return 32'h0;
        off = a[7:0] & 8'hFC;
        if (off == 8'h00) return ID;
        if (off == 8'h04) return {16'h0, m_ctrl};
        if (off == 8'h08) return m_scr;
        if (off == 8'h0C) return m_status;
        if (off == 8'h14) return {24'h0, m_stat};
        if (off == 8'h18) return {24'h0, m_mask};
        if (off >= 8'h20 && int'(off) < 32 + 4 * NC)
            return m_shadow[(int'(off) - 32) / 4];
        return 32'h0;
    endfunction

    // Advance the model by one rising edge using the inputs of the cycle.
    task automatic model_step();
        logic       irq_n;
        logic       snap;
        logic       clr;
        logic [7:0] clr_bits;
        logic [7:0] off;
        logic [31:0] d;
        if (up_rst) begin
            m_ctrl = CRST;
            m_scr = 0;
            m_status = 0;
            m_stat = 0;
            m_mask = 0;
            m_irq = 0;
            m_rd = 0;
            m_pend = 0;
            for (int i = 0; i < NC; i++) begin
                m_live[i] = 0;
                m_shadow[i] = 0;
            end
            chk_en = 1'b1;
            return;
        end
        irq_n = |(m_stat & m_mask);
        if (bus.up_rd) m_rd = mread(bus.up_addr);
        m_pend = bus.up_rd;
        snap = 0;
        clr = 0;
        clr_bits = 0;
        d = bus.up_data_wr;
        off = bus.up_addr[7:0] & 8'hFC;
        if (bus.up_wr && bus.up_addr[31:8] == BASE[31:8]) begin
            if (off == 8'h04) m_ctrl = d[15:0];
            if (off == 8'h08) m_scr = d;
            if (off == 8'h10) begin
                snap = d[0];
                clr = d[0] & d[1];
            end
            if (off == 8'h14) clr_bits = d[7:0];
            if (off == 8'h18) m_mask = d[7:0];
        end
        for (int i = 0; i < NC; i++) begin
            if (snap) m_shadow[i] = m_live[i];
            if (clr) m_live[i] = cnt_inc[i] ? 32 'd1 : 32'd0;
            else if (cnt_inc[i] && m_live[i] != 32'hFFFF_FFFF)
                m_live[i] = m_live[i] + 1;
        end
        m_stat = (m_stat & ~clr_bits) | irq_evt;
        m_status = status_in;
        m_irq = irq_n;
    endtask

    // One compare process, mid-cycle, against the model.
    always @(negedge up_clk) begin
        if (chk_en) begin
            chk("data_rd", bus.up_data_rd, m_rd);
            chk("wait", {31'h0, bus.up_wait},
                {31'h0, (bus.up_rd & ~up_rst) | m_pend});
            chk("ctrl", {16'h0, ctrl}, {16'h0, m_ctrl});
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    task automatic step();
        @(posedge up_clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.up_wr = 1'b1;
        bus.up_addr = a;
        bus.up_data_wr = d;
        step();
        bus.up_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.up_rd = 1'b1;
        bus.up_addr = a;
        #1;
        chk("wait_n", {31'h0, bus.up_wait}, 32'h1);
        step();
        bus.up_rd = 1'b0;
        chk("wait_n1", {31'h0, bus.up_wait}, 32'h1);
        v = bus.up_data_rd;
        step();
    endtask

    task automatic pulse_cnt(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            cnt_inc = '0;
            cnt_inc[idx] = 1'b1;
            step();
        end
        cnt_inc = '0;
    endtask

    logic [7:0] offs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                              8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C,
                              8'h30, 8'h40, 8'h10, 8'hFC};

    initial begin
        logic [31:0] v;
        up_rst = 1'b1;
        bus.up_wr = 0;
        bus.up_rd = 0;
        bus.up_addr = 0;
        bus.up_data_wr = 0;
        status_in = 32'h1357_9BDF;
        cnt_inc = '0;
        irq_evt = '0;
        step();
        step();
        up_rst = 1'b0;
        chk("rst_data_rd", bus.up_data_rd, 32'h0);
        chk("rst_wait", {31'h0, bus.up_wait}, 32'h0);
        chk("rst_ctrl", {16'h0, ctrl}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);

        rd(BASE + 32'h00, v); chk("id", v, 32'h5445_0001);
        rd(BASE + 32'h04, v); chk("ctrl_rst_rd", v, 32'h0);
        step();
        rd(BASE + 32'h0C, v); chk("status", v, 32'h1357_9BDF);

        wr(BASE + 32'h08, 32'hA5A5_5A5A);
        rd(BASE + 32'h08, v); chk("scratch", v, 32'hA5A5_5A5A);
        wr(BASE + 32'h04, 32'hFFFF_1234);
        chk("ctrl_out", {16'h0, ctrl}, 32'h0000_1234);
        rd(BASE + 32'h04, v); chk("ctrl_rd", v, 32'h0000_1234);
        rd(BASE + 32'h100, v); chk("miss_rd", v, 32'h0);
        wr(BASE + 32'h108, 32'h0);
        rd(BASE + 32'h08, v); chk("miss_wr", v, 32'hA5A5_5A5A);
        rd(BASE + 32'h10, v); chk("snap_rd", v, 32'h0);

        pulse_cnt(0, 5);
        wr(BASE + 32'h10, 32'h1);
        rd(BASE + 32'h20, v); chk("cnt0_5", v, 32'd5);
        pulse_cnt(0, 3);
        rd(BASE + 32'h20, v); chk("cnt0_hold", v, 32'd5);
        cnt_inc = 4'b0001;
        wr(BASE + 32'h10, 32'h3);
        cnt_inc = '0;
        rd(BASE + 32'h20, v); chk("cnt0_8", v, 32'd8);
        wr(BASE + 32'h10, 32'h1);
        rd(BASE + 32'h20, v); chk("cnt0_live1", v, 32'd1);

        force dut.g_cnt[1].live_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_cnt[1].live_q;
        m_live[1] = 32'hFFFF_FFFE;
        pulse_cnt(1, 3);
        wr(BASE + 32'h10, 32'h1);
        rd(BASE + 32'h24, v); chk("cnt1_sat", v, 32'hFFFF_FFFF);

        irq_evt = 8'h04;
        step();
        irq_evt = 8'h00;
        rd(BASE + 32'h14, v); chk("irq_stat", v, 32'h04);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        wr(BASE + 32'h18, 32'h04);
        chk("irq_n1", {31'h0, irq}, 32'h0);
        step();
        chk("irq_on", {31'h0, irq}, 32'h1);
        irq_evt = 8'h04;
        wr(BASE + 32'h14, 32'h04);
        irq_evt = 8'h00;
        rd(BASE + 32'h14, v); chk("set_wins", v, 32'h04);
        wr(BASE + 32'h14, 32'h04);
        chk("irq_still", {31'h0, irq}, 32'h1);
        step();
        chk("irq_off", {31'h0, irq}, 32'h0);

        wr(BASE + 32'h04, 32'h0000_BEEF);
        bus.up_rd = 1'b1;
        bus.up_addr = BASE + 32'h04;
        step();
        bus.up_rd = 1'b0;
        chk("pre_rst_rd", bus.up_data_rd, 32'h0000_BEEF);
        up_rst = 1'b1;
        step();
        chk("midrst_wait", {31'h0, bus.up_wait}, 32'h0);
        chk("midrst_data", bus.up_data_rd, 32'h0);
        chk("midrst_ctrl", {16'h0, ctrl}, {16'h0, CRST});
        up_rst = 1'b0;
        step();

        for (int c = 0; c < 3000; c++) begin
            up_rst = ($urandom_range(0, 499) == 0);
            bus.up_wr = ($urandom_range(0, 9) < 3);
            bus.up_rd = ($urandom_range(0, 9) < 3);
            bus.up_addr = {($urandom_range(0, 9) == 0) ? BASE[31:8] + 24'h1
                                                        : BASE[31:8],
                           offs[$urandom_range(0, 15)] | 8'($urandom_range(0, 3))};
            bus.up_data_wr = $urandom;
            status_in = $urandom;
            cnt_inc = NC'($urandom);
            irq_evt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            step();
        end
        up_rst = 0;
        bus.up_wr = 0;
        bus.up_rd = 0;
        cnt_inc = '0;
        irq_evt = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
